wr_image: RTL and testbench

Frame-buffer writer: accepts a 24-bit RGB pixel stream with a start-of-frame marker over a valid/ready handshake and writes each frame sequentially into a double-banked BRAM (two FRAME_W×FRAME_H banks). Sits upstream of the image read path. The reader consumes the bank opposite `wr_bank`, so a completed frame is never overwritten while it is being read.

---
 rtl/image_pkg.sv | 13 +
 rtl/wr_image.sv | 104 ++++++++++
 tb/tb_wr_image.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/image_pkg.sv
// image_pkg: frame geometry, pixel width, FSM encoding and stop address shared by image write/read paths
package image_pkg;
  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int PIX_W = 24;
  localparam int IMG_STOP = IMG_W * IMG_H - 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  function automatic int stop_addr(input int w, input int h);
    return w * h - 1;
  endfunction
endpackage

// File: rtl/wr_image.sv
// wr_image: frame-buffer writer, RGB pixel stream (valid/ready + sof) into a double-banked BRAM.
//   in : clk, rst (sync, active-high), cap_en, pix_valid, pix_sof, pix_data
//   out: pix_ready, ram_we, ram_addr {bank, addr}, ram_din, wr_bank, frame_done, err_sof, err_cnt
//   WR_IMAGE_ERR_CNT_EN: when defined, err_cnt counts err_sof pulses (saturating); otherwise tied to 0.
module wr_image
  import image_pkg::*;
#(
  parameter int FRAME_W = IMG_W,
  parameter int FRAME_H = IMG_H,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              wr_bank,
  output logic              frame_done,
  output logic              err_sof,
  output logic [7:0]        err_cnt
);
  localparam logic [ADDR_W-1:0] STOP = ADDR_W'(stop_addr(FRAME_W, FRAME_H));
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic bank_q, bank_d, we_q, we_d, err_q, err_d, acc;
  assign pix_ready = state_q != S_DONE;
  assign acc = pix_valid & pix_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bank_d = bank_q;
    we_d = 1'b0;
    err_d = 1'b0;
    addr_d = addr_q;
    din_d = din_q;
    case (state_q)
      S_IDLE: if (acc && pix_sof && cap_en) begin
        we_d = 1'b1;
        addr_d = {bank_q, {ADDR_W{1'b0}}};
        din_d = pix_data;
        cnt_d = ADDR_W'(1);
        state_d = S_WRITE;
      end
      S_WRITE: if (acc) begin
        we_d = 1'b1;
        din_d = pix_data;
        err_d = pix_sof;
        addr_d = {bank_q, pix_sof ? {ADDR_W{1'b0}} : cnt_q};
        cnt_d = pix_sof ? ADDR_W'(1) : (cnt_q == STOP ? cnt_q : cnt_q + ADDR_W'(1));
        state_d = (!pix_sof && cnt_q == STOP) ? S_DONE : S_WRITE;
      end
      default: begin
        bank_d = ~bank_q;
        cnt_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bank_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bank_q <= bank_d;
      we_q <= we_d;
      err_q <= err_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  end
  assign ram_we = we_q;
  assign ram_addr = addr_q;
  assign ram_din = din_q;
  assign wr_bank = bank_q;
  assign err_sof = err_q;
  // DONE lasts one cycle, coinciding with the registered write of the last pixel
  assign frame_done = state_q == S_DONE;
`ifdef WR_IMAGE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  assign err_cnt_d = (err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else err_cnt_q <= err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_wr_image.sv
// tb_wr_image: directed scoreboard bench for wr_image with a 4x4 frame
module tb_wr_image;
  logic clk = 1'b0, rst = 1'b1, cap_en = 1'b0, pix_valid = 1'b0, pix_sof = 1'b0;
  logic [23:0] pix_data = '0;
  logic pix_ready, ram_we, wr_bank, frame_done, err_sof, a;
  logic [4:0] ram_addr;
  logic [23:0] ram_din;
  logic [7:0] err_cnt;
  int tests = 0, fails = 0, ndone = 0, ngap = 0, mst = 0;
  logic [3:0] mcnt = '0;
  logic mbank = 1'b0;
  logic [28:0] sb[$];
  wr_image #(.FRAME_W(4), .FRAME_H(4), .ADDR_W(4), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_data(pix_data), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .wr_bank(wr_bank), .frame_done(frame_done), .err_sof(err_sof),
    .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic s, input logic c, input logic r,
                     input logic [23:0] d, output logic acc);
    logic ew, edn, ee;
    logic [28:0] e;
    ew = 1'b0;
    edn = 1'b0;
    ee = 1'b0;
    acc = 1'b0;
    pix_valid = v;
    pix_sof = s;
    cap_en = c;
    rst = r;
    pix_data = d;
    if (r) begin
      mst = 0;
      mcnt = '0;
      mbank = 1'b0;
      sb.delete();
    end else begin
      chk("pix_ready", pix_ready, mst != 2);
      if (!pix_ready) ngap++;
      acc = v && mst != 2;
      if (mst == 2) begin
        mbank = ~mbank;
        mst = 0;
        mcnt = '0;
      end else if (mst == 1 && acc) begin
        ew = 1'b1;
        ee = s;
        sb.push_back({mbank, s ? 4'd0 : mcnt, d});
        if (s) mcnt = 4'd1;
        else if (mcnt == 4'd15) begin
          mst = 2;
          edn = 1'b1;
        end else mcnt++;
      end else if (mst == 0 && acc && s && c) begin
        ew = 1'b1;
        sb.push_back({mbank, 4'd0, d});
        mcnt = 4'd1;
        mst = 1;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_din", ram_din, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", err_sof, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_bank", wr_bank, 0);
      chk("rst_ready", pix_ready, 1);
    end else begin
      chk("ram_we", ram_we, ew);
      if (ew) begin
        e = sb.pop_front();
        chk("ram_addr", ram_addr, e[28:24]);
        chk("ram_din", ram_din, e[23:0]);
      end
      chk("frame_done", frame_done, edn);
      chk("err_sof", err_sof, ee);
      chk("wr_bank", wr_bank, mbank);
    end
    if (frame_done) ndone++;
  endtask
  task automatic send(input int n, input int sof2, input logic sof0, input logic c, input logic tog);
    int k, cycles;
    logic ac;
    k = 0;
    cycles = 0;
    while (k < n && cycles < n * 3 + 10) begin
      cyc(1'b1, (k == 0 && sof0) || k == sof2, c, 1'b0, 24'(k) * 24'h010101, ac);
      cycles++;
      if (ac) begin
        k++;
        if (tog) begin
          cyc(1'b0, 1'b0, c, 1'b0, 24'h0, ac);
          cycles++;
        end
      end
    end
    chk("send_timeout", k, n);
  endtask
  task automatic idle(input int n);
    logic ac;
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, ac);
  endtask
  task automatic do_reset();
    logic ac;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0, ac);
    ndone = 0;
    ngap = 0;
  endtask
  initial begin
    do_reset();
    do_reset();
    send(16, -1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("s1_done_cnt", ndone, 1);
    chk("s1_bank", wr_bank, 1);
    do_reset();
    send(32, 16, 1'b1, 1'b1, 1'b0);
    chk("s2_gap", ngap, 1);
    idle(1);
    chk("s2_done_cnt", ndone, 2);
    chk("s2_bank", wr_bank, 0);
    do_reset();
    send(22, 6, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("s3_done_cnt", ndone, 1);
`ifdef WR_IMAGE_ERR_CNT_EN
    chk("s3_err_cnt", err_cnt, 1);
`else
    chk("s3_err_cnt", err_cnt, 0);
`endif
    do_reset();
    send(16, -1, 1'b1, 1'b0, 1'b0);
    send(5, -1, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("s4_done_cnt", ndone, 0);
    chk("s4_gap", ngap, 0);
    chk("s4_bank", wr_bank, 0);
    do_reset();
    send(16, -1, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("s5_done_cnt", ndone, 1);
    do_reset();
    send(10, -1, 1'b1, 1'b1, 1'b0);
    do_reset();
    idle(1);
    send(16, -1, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("s6_done_cnt", ndone, 1);
    chk("s6_bank", wr_bank, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
